// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator for a big-endian, byte-addressed data
// memory with a 1-cycle registered read and a 4-byte write per clock edge.
// Sub-word stores are done as read-modify-write of the 4 bytes starting at
// the request address. All outputs are registered.
module lsu_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR,
    RESP
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  state_t state, state_nxt;

  // Request fields still needed after acceptance. The address lives in the
  // mem_addr register itself, and word-store data goes straight into
  // mem_wdata, so only the low half of the store data is kept here.
  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [15:0] wdata_q;

  logic              accept;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  logic              ready_nxt;
  logic              valid_nxt;
  logic              err_nxt;
  logic [31:0]       rdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              we_nxt;
  logic [31:0]       wdata_nxt;

  assign accept = req_valid && req_ready;

  assign req_err = (req_size == SIZE_RSVD) ||
                   (CHECK_ALIGN &&
                    (((req_size == SIZE_HALF) && req_addr[0]) ||
                     ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))));

  // Big-endian: the addressed byte/half sits in the top of the read word.
  always_comb begin
    load_data = mem_rdata;
    case (size_q)
      SIZE_BYTE: load_data = uns_q ? {24'h0, mem_rdata[31:24]}
                                   : {{24{mem_rdata[31]}}, mem_rdata[31:24]};
      SIZE_HALF: load_data = uns_q ? {16'h0, mem_rdata[31:16]}
                                   : {{16{mem_rdata[31]}}, mem_rdata[31:16]};
      default:   load_data = mem_rdata;
    endcase
  end

  // Splice the store data over the top byte/half of the word just read.
  always_comb begin
    merge_data = {wdata_q, mem_rdata[15:0]};
    if (size_q == SIZE_BYTE) begin
      merge_data = {wdata_q[7:0], mem_rdata[23:0]};
    end
  end

  // Next state and next registered output values.
  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = resp_rdata;
    addr_nxt  = mem_addr;
    we_nxt    = 1'b0;
    wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nxt = RESP;
            valid_nxt = 1'b1;
            err_nxt   = 1'b1;
            rdata_nxt = 32'h0;
          end else if (req_write && (req_size == SIZE_WORD)) begin
            state_nxt = WR;
            addr_nxt  = req_addr;
            we_nxt    = 1'b1;
            wdata_nxt = req_wdata;
          end else begin
            state_nxt = RD_ISSUE;
            addr_nxt  = req_addr;
          end
        end
      end
      RD_ISSUE: begin
        state_nxt = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        if (wr_q) begin
          state_nxt = WR;
          we_nxt    = 1'b1;
          wdata_nxt = merge_data;
        end else begin
          state_nxt = RESP;
          valid_nxt = 1'b1;
          rdata_nxt = load_data;
        end
      end
      WR: begin
        state_nxt = RESP;
        valid_nxt = 1'b1;
        rdata_nxt = 32'h0;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ready_nxt = (state_nxt == IDLE);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= 32'h0;
    end else begin
      state      <= state_nxt;
      req_ready  <= ready_nxt;
      resp_valid <= valid_nxt;
      resp_err   <= err_nxt;
      resp_rdata <= rdata_nxt;
      mem_addr   <= addr_nxt;
      mem_we     <= we_nxt;
      mem_wdata  <= wdata_nxt;
    end
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 16'h0;
    end else if (accept) begin
      wr_q    <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata[15:0];
    end
  end

endmodule
